// File: rtl/oldest2_issue_sched.sv
// rtl/oldest2_issue_sched.sv - circular issue buffer picking the two oldest ready entries per cycle
// Dispatches with operands available may bypass the buffer straight into a free issue slot.
module oldest2_issue_sched #(
  parameter int DEPTH     = 8,
  parameter int PTR_WIDTH = 3,
  parameter int TAG_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 disp0_valid_i,
  input  logic                 disp1_valid_i,
  input  logic [TAG_WIDTH-1:0] disp0_tag_i,
  input  logic [TAG_WIDTH-1:0] disp1_tag_i,
  input  logic [TAG_WIDTH-1:0] disp0_wait_i,
  input  logic [TAG_WIDTH-1:0] disp1_wait_i,
  input  logic                 disp0_rdy_i,
  input  logic                 disp1_rdy_i,
  output logic                 disp_ready_o,
  input  logic                 wakeup_valid_i,
  input  logic [TAG_WIDTH-1:0] wakeup_tag_i,
  output logic                 iss0_valid_o,
  output logic                 iss1_valid_o,
  output logic [TAG_WIDTH-1:0] iss0_tag_o,
  output logic [TAG_WIDTH-1:0] iss1_tag_o,
  input  logic                 iss0_ready_i,
  input  logic                 iss1_ready_i,
  output logic [PTR_WIDTH:0]   occupancy_o
);

  localparam logic [PTR_WIDTH:0] SPAN_MAX = (PTR_WIDTH+1)'(DEPTH-2);

  logic [DEPTH-1:0]     ent_valid, ent_rdy;
  logic [TAG_WIDTH-1:0] ent_tag  [DEPTH];
  logic [TAG_WIDTH-1:0] ent_wait [DEPTH];
  logic [PTR_WIDTH:0]   head, tail, occ;
  logic [PTR_WIDTH:0]   span;

  logic                 sel0_found, sel1_found;
  logic [PTR_WIDTH-1:0] sel0_idx, sel1_idx, scan_idx;

  logic acc0, acc1, wake0, wake1, byp0_ok, byp1_ok;
  logic d0_slot0, d0_slot1, d1_slot0, d1_slot1, any0, any1;
  logic fire0, fire1, free0, free1, wr0, wr1;
  logic [PTR_WIDTH-1:0] w0_idx, w1_idx;
  logic [DEPTH-1:0]     valid_nx, rdy_nx;
  logic [PTR_WIDTH:0]   head_nx;

  assign span         = tail - head;
  assign disp_ready_o = !rst && !flush_i && (span <= SPAN_MAX);
  assign occupancy_o  = occ;

  assign acc0    = disp_ready_o && disp0_valid_i;
  assign acc1    = disp_ready_o && disp1_valid_i;
  assign wake0   = wakeup_valid_i && (disp0_wait_i == wakeup_tag_i);
  assign wake1   = wakeup_valid_i && (disp1_wait_i == wakeup_tag_i);
  assign byp0_ok = acc0 && disp0_rdy_i;
  assign byp1_ok = acc1 && disp1_rdy_i;

  // Age-ordered scan starting from head; holes between head and tail are skipped.
  always_comb begin
    sel0_found = 1'b0;
    sel1_found = 1'b0;
    sel0_idx   = '0;
    sel1_idx   = '0;
    scan_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head[PTR_WIDTH-1:0] + PTR_WIDTH'(i);
      if (ent_valid[scan_idx] && ent_rdy[scan_idx]) begin
        if (!sel0_found) begin
          sel0_found = 1'b1;
          sel0_idx   = scan_idx;
        end else if (!sel1_found) begin
          sel1_found = 1'b1;
          sel1_idx   = scan_idx;
        end
      end
    end
  end

  // Slot fill priority: buffered entries, then disp0, then disp1.
  always_comb begin
    d0_slot0 = 1'b0;
    d0_slot1 = 1'b0;
    d1_slot0 = 1'b0;
    d1_slot1 = 1'b0;
    if (sel0_found) begin
      if (!sel1_found) begin
        if (byp0_ok)      d0_slot1 = 1'b1;
        else if (byp1_ok) d1_slot1 = 1'b1;
      end
    end else if (byp0_ok) begin
      d0_slot0 = 1'b1;
      d1_slot1 = byp1_ok;
    end else if (byp1_ok) begin
      d1_slot0 = 1'b1;
    end
  end

  assign any0 = sel0_found || d0_slot0 || d1_slot0;
  assign any1 = sel1_found || d0_slot1 || d1_slot1;
  assign iss0_valid_o = any0 && !rst && !flush_i;
  assign iss1_valid_o = any1 && !rst && !flush_i;
  assign iss0_tag_o = sel0_found ? ent_tag[sel0_idx] : (d0_slot0 ? disp0_tag_i : disp1_tag_i);
  assign iss1_tag_o = sel1_found ? ent_tag[sel1_idx] : (d0_slot1 ? disp0_tag_i : disp1_tag_i);

  assign fire0 = iss0_valid_o && iss0_ready_i;
  assign fire1 = iss1_valid_o && iss1_ready_i;
  assign free0 = sel0_found && fire0;
  assign free1 = sel1_found && fire1;
  assign wr0   = acc0 && !((d0_slot0 && fire0) || (d0_slot1 && fire1));
  assign wr1   = acc1 && !((d1_slot0 && fire0) || (d1_slot1 && fire1));
  assign w0_idx = tail[PTR_WIDTH-1:0];
  assign w1_idx = tail[PTR_WIDTH-1:0] + PTR_WIDTH'(wr0);

  always_comb begin
    valid_nx = ent_valid;
    rdy_nx   = ent_rdy;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && wakeup_valid_i && (ent_wait[i] == wakeup_tag_i)) rdy_nx[i] = 1'b1;
    end
    if (free0) valid_nx[sel0_idx] = 1'b0;
    if (free1) valid_nx[sel1_idx] = 1'b0;
    if (wr0) begin
      valid_nx[w0_idx] = 1'b1;
      rdy_nx[w0_idx]   = disp0_rdy_i || wake0;
    end
    if (wr1) begin
      valid_nx[w1_idx] = 1'b1;
      rdy_nx[w1_idx]   = disp1_rdy_i || wake1;
    end
    // Retire up to two holes at head, bounded by the pre-write tail.
    head_nx = head;
    for (int k = 0; k < 2; k++) begin
      if (head_nx != tail && !valid_nx[head_nx[PTR_WIDTH-1:0]]) head_nx = head_nx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
      ent_rdy   <= '0;
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
    end else if (flush_i) begin
      ent_valid <= '0;
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
    end else begin
      ent_valid <= valid_nx;
      ent_rdy   <= rdy_nx;
      head      <= head_nx;
      tail      <= tail + (PTR_WIDTH+1)'(wr0) + (PTR_WIDTH+1)'(wr1);
      occ       <= occ + (PTR_WIDTH+1)'(wr0) + (PTR_WIDTH+1)'(wr1)
                       - (PTR_WIDTH+1)'(free0) - (PTR_WIDTH+1)'(free1);
      if (wr0) begin
        ent_tag[w0_idx]  <= disp0_tag_i;
        ent_wait[w0_idx] <= disp0_wait_i;
      end
      if (wr1) begin
        ent_tag[w1_idx]  <= disp1_tag_i;
        ent_wait[w1_idx] <= disp1_wait_i;
      end
    end
  end

endmodule

// File: tb/tb_oldest2_issue_sched.sv
// tb/tb_oldest2_issue_sched.sv - directed self-checking bench for oldest2_issue_sched
module tb_oldest2_issue_sched;
  logic       clk = 1'b0;
  logic       rst, flush_i;
  logic       disp0_valid_i, disp1_valid_i, disp0_rdy_i, disp1_rdy_i;
  logic [5:0] disp0_tag_i, disp1_tag_i, disp0_wait_i, disp1_wait_i;
  logic       disp_ready_o, wakeup_valid_i;
  logic [5:0] wakeup_tag_i, iss0_tag_o, iss1_tag_o;
  logic       iss0_valid_o, iss1_valid_o, iss0_ready_i, iss1_ready_i;
  logic [3:0] occupancy_o;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  oldest2_issue_sched dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .disp0_valid_i(disp0_valid_i), .disp1_valid_i(disp1_valid_i),
    .disp0_tag_i(disp0_tag_i), .disp1_tag_i(disp1_tag_i),
    .disp0_wait_i(disp0_wait_i), .disp1_wait_i(disp1_wait_i),
    .disp0_rdy_i(disp0_rdy_i), .disp1_rdy_i(disp1_rdy_i),
    .disp_ready_o(disp_ready_o),
    .wakeup_valid_i(wakeup_valid_i), .wakeup_tag_i(wakeup_tag_i),
    .iss0_valid_o(iss0_valid_o), .iss1_valid_o(iss1_valid_o),
    .iss0_tag_o(iss0_tag_o), .iss1_tag_o(iss1_tag_o),
    .iss0_ready_i(iss0_ready_i), .iss1_ready_i(iss1_ready_i),
    .occupancy_o(occupancy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush_i = 0; disp0_valid_i = 0; disp1_valid_i = 0; disp0_rdy_i = 0; disp1_rdy_i = 0;
    disp0_tag_i = 0; disp1_tag_i = 0; disp0_wait_i = 0; disp1_wait_i = 0;
    wakeup_valid_i = 0; wakeup_tag_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d0(input logic [5:0] tag, input logic [5:0] w, input logic r);
    disp0_valid_i = 1; disp0_tag_i = tag; disp0_wait_i = w; disp0_rdy_i = r;
  endtask

  task automatic d1(input logic [5:0] tag, input logic [5:0] w, input logic r);
    disp1_valid_i = 1; disp1_tag_i = tag; disp1_wait_i = w; disp1_rdy_i = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1; iss0_ready_i = 1; iss1_ready_i = 1;
    tick(); tick();
    chk("rst_iss0_valid", iss0_valid_o, 0);
    chk("rst_iss1_valid", iss1_valid_o, 0);
    chk("rst_disp_ready", disp_ready_o, 0);
    rst = 0; #1;
    chk("reset_occ", occupancy_o, 0);
    chk("reset_disp_ready", disp_ready_o, 1);

    // Dual bypass, both accepted
    d0(5, 0, 1); d1(6, 0, 1); #1;
    chk("byp_iss0_valid", iss0_valid_o, 1);
    chk("byp_iss0_tag", iss0_tag_o, 5);
    chk("byp_iss1_valid", iss1_valid_o, 1);
    chk("byp_iss1_tag", iss1_tag_o, 6);
    tick(); idle(); #1;
    chk("byp_occ", occupancy_o, 0);

    // Fill eight entries waiting on tag 9
    for (int k = 0; k < 4; k++) begin
      d0(6'(10 + 2*k), 9, 0); d1(6'(11 + 2*k), 9, 0); #1;
      chk("fill_disp_ready", disp_ready_o, 1);
      chk("fill_no_issue", iss0_valid_o, 0);
      tick(); idle();
    end
    #1;
    chk("full_disp_ready", disp_ready_o, 0);
    chk("full_occ", occupancy_o, 8);
    wakeup_valid_i = 1; wakeup_tag_i = 9; #1;
    chk("wake_cycle_no_issue", iss0_valid_o, 0);
    tick(); idle(); #1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_iss0_tag", iss0_tag_o, 10 + 2*k);
      chk("drain_iss1_tag", iss1_tag_o, 11 + 2*k);
      chk("drain_iss1_valid", iss1_valid_o, 1);
      tick(); #1;
    end
    chk("drain_occ", occupancy_o, 0);
    chk("drain_head_wrap", dut.head, 8);
    chk("drain_tail_wrap", dut.tail, 8);

    // Slots 2 and 4 ready, only slot 1 accepted
    iss0_ready_i = 0; iss1_ready_i = 0;
    d0(20, 1, 0); d1(21, 1, 0); tick(); idle();
    d0(22, 0, 1); d1(23, 1, 0); #1;
    chk("nack_bypass_offered", iss0_tag_o, 22);
    tick(); idle();
    d0(24, 0, 1); #1;
    chk("prio_buf_slot0", iss0_tag_o, 22);
    chk("prio_byp_slot1", iss1_tag_o, 24);
    chk("prio_byp_valid", iss1_valid_o, 1);
    tick(); idle(); #1;
    chk("part_occ_before", occupancy_o, 5);
    iss1_ready_i = 1; #1;
    chk("part_iss0_tag", iss0_tag_o, 22);
    chk("part_iss1_tag", iss1_tag_o, 24);
    tick(); iss1_ready_i = 0; #1;
    chk("part_occ_after", occupancy_o, 4);
    chk("part_reoffer_tag", iss0_tag_o, 22);
    chk("part_reoffer_valid", iss0_valid_o, 1);
    chk("part_iss1_empty", iss1_valid_o, 0);

    // Wakeup coincident with dispatch: written ready, no bypass
    d0(30, 3, 0); wakeup_valid_i = 1; wakeup_tag_i = 3; #1;
    chk("wdisp_no_bypass", iss1_valid_o, 0);
    tick(); idle(); #1;
    chk("wdisp_next_valid", iss1_valid_o, 1);
    chk("wdisp_next_tag", iss1_tag_o, 30);
    chk("wdisp_occ", occupancy_o, 5);

    // Flush with five entries plus a dispatch
    iss0_ready_i = 1; iss1_ready_i = 1;
    flush_i = 1; d0(40, 0, 1); #1;
    chk("flush_iss0_valid", iss0_valid_o, 0);
    chk("flush_iss1_valid", iss1_valid_o, 0);
    chk("flush_disp_ready", disp_ready_o, 0);
    tick(); idle(); #1;
    chk("flush_occ", occupancy_o, 0);
    chk("flush_head", dut.head, 0);
    chk("flush_tail", dut.tail, 0);
    chk("flush_after_ready", disp_ready_o, 1);

    // Span boundary with single dispatches
    for (int k = 0; k < 7; k++) begin
      d0(6'(50 + k), 2, 0); #1;
      chk("span_ready", disp_ready_o, 1);
      tick(); idle();
    end
    #1;
    chk("span7_not_ready", disp_ready_o, 0);
    chk("span7_occ", occupancy_o, 7);

    // Reset mid-drain
    wakeup_valid_i = 1; wakeup_tag_i = 2; tick(); idle(); #1;
    chk("mid_iss0_tag", iss0_tag_o, 50);
    chk("mid_iss1_tag", iss1_tag_o, 51);
    tick(); #1;
    chk("mid_occ", occupancy_o, 5);
    rst = 1; #1;
    chk("mid_rst_iss0", iss0_valid_o, 0);
    chk("mid_rst_iss1", iss1_valid_o, 0);
    chk("mid_rst_ready", disp_ready_o, 0);
    tick(); rst = 0; #1;
    chk("post_rst_occ", occupancy_o, 0);
    chk("post_rst_iss0", iss0_valid_o, 0);
    chk("post_rst_ready", disp_ready_o, 1);
    chk("post_rst_tail", dut.tail, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
